single_cycle_cpu_display: RTL and testbench
===========================================

SINGLE_CYCLE_CPU_DISPLAY -- requirements
Module: single_cycle_cpu_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive equal synchronized btn_clk samples required before a level is accepted.
REQ-002 Parameter LCD_DIV, default 2: clk cycles per half-period of the serial display strobe lcd_wr.
REQ-003 clk  input  1  sole system clock; all state is updated on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 btn_clk  input  1  single-step button, asynchronous to clk.
REQ-006 input_sel  input  2  display source select: 0=PC, 1=current instruction, 2=register $3, 3=register $5.
REQ-007 lcd_rst  output  1  display reset, active low.
REQ-008 lcd_cs  output  1  display frame select, active low.
REQ-009 lcd_rs  output  1  serial display data bit.
REQ-010 lcd_wr  output  1  serial display strobe; the receiver samples lcd_rs on its rising edge.
REQ-011 lcd_rd  output  1  display read strobe, held at 1.
REQ-012 lcd_bl_ctr  output  1  backlight enable, held at 1.
REQ-013 ct_int  input  1  touch interrupt; ignored.
REQ-014 ct_sda  inout  1  touch data line; always driven high-Z.
REQ-015 ct_scl  output  1  touch clock line, held at 1.
REQ-016 ct_rstn  output  1  touch controller reset, active low.

Function
REQ-017 btn_clk passes through a 2-flop synchronizer and a DEBOUNCE_CYCLES debounce filter.
REQ-018 Each accepted 0->1 transition of btn_clk produces a one-clk step pulse; the CPU executes exactly one instruction per step pulse.
REQ-019 Holding btn_clk high produces no further steps, and bounces shorter than DEBOUNCE_CYCLES produce no step.
REQ-020 CPU state: 32-bit byte-addressed PC; 32x32 register file with $0 reading 0 and ignoring writes; 16-word data memory addressed by addr[5:2].
REQ-021 Instruction ROM is combinational and indexed by PC[5:2]; addresses beyond word 8 read 0x00000000, which executes as a NOP.
REQ-022 Fixed ROM program: w0 0x24010001 (addiu $1,$0,1); w1 0x24020005 (addiu $2,$0,5); w2 0x00221821 (addu $3,$1,$2).
REQ-023 ROM continued: w3 0xAC030000 (sw $3,0($0)); w4 0x8C040000 (lw $4,0($0)); w5 0x10830001 (beq $4,$3,+1); w6 0x240500FF (addiu $5,$0,0xFF); w7 0x00812823 (subu $5,$4,$1); w8 0x08000008 (j 8, halt loop).
REQ-024 Supported instructions: addu, subu, and, or, slt (R-type), plus addiu, lw, sw, beq, j.
REQ-025 Unsupported opcodes and funct codes execute as NOP with PC+4.
REQ-026 Arithmetic is 32-bit modulo 2^32; immediates are sign-extended; slt compares signed.
REQ-027 Branch target = PC+4+(sext(imm)<<2); jump target = {PC+4[31:28], target26, 2'b00}.
REQ-028 Display value = mux(input_sel) sampled at each frame start; a change of input_sel mid-frame takes effect on the next frame.
REQ-029 Frame sequence: lcd_cs falls, then 32 bits are sent MSB first, then lcd_cs returns high for 2*LCD_DIV clks before the next frame starts.
REQ-030 Per bit: lcd_rs is set while lcd_wr goes low for LCD_DIV clks, then lcd_wr is high for LCD_DIV clks.
REQ-031 Frames repeat continuously.
REQ-032 lcd_wr is 1 whenever lcd_cs is 1.
REQ-033 A step pulse and a frame may occur simultaneously; the frame shows the value latched at its start.

Reset
REQ-034 While resetn=0, asynchronously: PC=0, all registers and data memory=0, debounce and step logic cleared, display FSM idle.
REQ-035 While resetn=0: lcd_cs=1, lcd_wr=1, lcd_rs=0, lcd_rst=0, ct_rstn=0.
REQ-036 lcd_rst and ct_rstn go to 1 on the first clk edge after resetn deasserts.
REQ-037 A reset asserted mid-frame or mid-debounce aborts the operation immediately; the first frame starts no earlier than 1 clk after release.
REQ-038 btn_clk activity during reset produces no step.

Verification
REQ-039 Reset, no steps, input_sel=0 -> frames carry 0x00000000; input_sel=1 -> frames carry 0x24010001.
REQ-040 Three clean presses -> PC=0x0000000C; input_sel=2 -> frames carry 0x00000006.
REQ-041 Nine presses -> $5=0x00000005 (branch taken, w6 skipped); input_sel=3 -> 0x00000005; input_sel=0 -> 0x00000020.
REQ-042 Further presses after nine -> PC stays 0x00000020.
REQ-043 A btn_clk glitch of DEBOUNCE_CYCLES-1 clks -> no step; a level held high for 1000 clks -> exactly one step.
REQ-044 resetn pulsed low mid-frame after five steps -> lcd_cs=1 immediately; PC, $3 and $5 read 0; lcd_rst is low during reset and high 1 clk after release.

Source files
------------

// File: rtl/single_cycle_cpu_display.sv
// Single-step MIPS-subset CPU with a debounced step button and a serial display
// that continuously shifts out a selectable 32-bit debug value, MSB first.
module single_cycle_cpu_display #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LCD_DIV         = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_clk,
    input  logic [1:0] input_sel,
    output logic       lcd_rst,
    output logic       lcd_cs,
    output logic       lcd_rs,
    output logic       lcd_wr,
    output logic       lcd_rd,
    output logic       lcd_bl_ctr,
    input  logic       ct_int,
    inout  wire        ct_sda,
    output logic       ct_scl,
    output logic       ct_rstn
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(2 * LCD_DIV + 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] HALF_MAX = DIV_W'(LCD_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_MAX  = DIV_W'(2 * LCD_DIV - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] ST_GAP  = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    // ------------------------------------------------------------------
    // Static pins and power-on release of the display/touch resets
    // ------------------------------------------------------------------
    logic rst_done_q;
    logic unused_ok;

    assign lcd_rd     = 1'b1;
    assign lcd_bl_ctr = 1'b1;
    assign ct_scl     = 1'b1;
    assign ct_sda     = 1'bz;
    assign lcd_rst    = rst_done_q;
    assign ct_rstn    = rst_done_q;
    assign unused_ok  = ct_int;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_done_q <= 1'b0;
        else         rst_done_q <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Button synchronizer, debounce filter and step pulse
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic            db_level_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            step_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            step_q     <= 1'b0;
        end else begin
            sync1_q <= btn_clk;
            sync2_q <= sync1_q;
            step_q  <= 1'b0;
            if (sync2_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_MAX) begin
                db_level_q <= sync2_q;
                db_cnt_q   <= '0;
                step_q     <= sync2_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU datapath: one instruction retires per step pulse
    // ------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [16];
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [31:0] rs_val, rt_val, imm_sext, pc_plus4, addr_sum;
    logic        rf_we, mem_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always_comb begin
        case (pc_q[5:2])
            4'd0:    instr = 32'h24010001;
            4'd1:    instr = 32'h24020005;
            4'd2:    instr = 32'h00221821;
            4'd3:    instr = 32'hAC030000;
            4'd4:    instr = 32'h8C040000;
            4'd5:    instr = 32'h10830001;
            4'd6:    instr = 32'h240500FF;
            4'd7:    instr = 32'h00812823;
            4'd8:    instr = 32'h08000008;
            default: instr = 32'h00000000;
        endcase
    end

    assign opcode   = instr[31:26];
    assign rs_a     = instr[25:21];
    assign rt_a     = instr[20:16];
    assign rd_a     = instr[15:11];
    assign funct    = instr[5:0];
    assign rs_val   = (rs_a == 5'd0) ? 32'h0 : rf_q[rs_a];
    assign rt_val   = (rt_a == 5'd0) ? 32'h0 : rf_q[rt_a];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign pc_plus4 = pc_q + 32'd4;
    assign addr_sum = rs_val + imm_sext;

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d     = pc_plus4;
        rf_we    = 1'b0;
        rf_waddr = rd_a;
        rf_wdata = 32'h0;
        mem_we   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rf_we = 1'b1;
                case (funct)
                    FN_ADDU: rf_wdata = rs_val + rt_val;
                    FN_SUBU: rf_wdata = rs_val - rt_val;
                    FN_AND:  rf_wdata = rs_val & rt_val;
                    FN_OR:   rf_wdata = rs_val | rt_val;
                    FN_SLT:  rf_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    default: rf_we    = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                rf_we    = 1'b1;
                rf_waddr = rt_a;
                rf_wdata = addr_sum;
            end
            OP_LW: begin
                rf_we    = 1'b1;
                rf_waddr = rt_a;
                rf_wdata = dmem_q[addr_sum[5:2]];
            end
            OP_SW:  mem_we = 1'b1;
            OP_BEQ: if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
            OP_J:   pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
    end

    // NOTE: register file and data memory are reset explicitly because a reset must read back as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q <= 32'h0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
            for (int i = 0; i < 16; i++) dmem_q[i] <= 32'h0;
        end else if (step_q) begin
            pc_q <= pc_d;
            if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
            if (mem_we) dmem_q[addr_sum[5:2]] <= rt_val;
        end
    end

    // ------------------------------------------------------------------
    // Serial display: gap (cs high), then 32 bits of wr-low / wr-high
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      shift_q, shift_d;
    logic [31:0]      disp_val;

    always_comb begin
        case (input_sel)
            2'd0:    disp_val = pc_q;
            2'd1:    disp_val = instr;
            2'd2:    disp_val = rf_q[3];
            default: disp_val = rf_q[5];
        endcase
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_GAP: if (div_q == GAP_MAX) begin
                state_d = ST_LOW;
                div_d   = '0;
                bit_d   = 5'd0;
                shift_d = disp_val;
            end
            ST_LOW: if (div_q == HALF_MAX) begin
                state_d = ST_HIGH;
                div_d   = '0;
            end
            ST_HIGH: if (div_q == HALF_MAX) begin
                div_d = '0;
                if (bit_q == 5'd31) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_LOW;
                    bit_d   = bit_q + 5'd1;
                    shift_d = {shift_q[30:0], 1'b0};
                end
            end
            default: begin
                state_d = ST_GAP;
                div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_GAP;
            div_q   <= '0;
            bit_q   <= 5'd0;
            shift_q <= 32'h0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign lcd_cs = (state_q == ST_GAP);
    assign lcd_wr = (state_q != ST_LOW);
    assign lcd_rs = !lcd_cs && shift_q[31];

endmodule

// File: tb/tb_single_cycle_cpu_display.sv
// Scoreboard bench: expected frame values are queued as the display source is
// selected, then popped and compared against frames decoded from lcd_cs/lcd_wr/lcd_rs.
module tb_single_cycle_cpu_display;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LCD_DIV         = 2;
    localparam int FRAME_BUDGET    = 1000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       btn_clk;
    logic [1:0] input_sel;
    logic       lcd_rst, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_bl_ctr;
    logic       ct_int;
    wire        ct_sda;
    logic       ct_scl, ct_rstn;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    single_cycle_cpu_display #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LCD_DIV        (LCD_DIV)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .btn_clk   (btn_clk),
        .input_sel (input_sel),
        .lcd_rst   (lcd_rst),
        .lcd_cs    (lcd_cs),
        .lcd_rs    (lcd_rs),
        .lcd_wr    (lcd_wr),
        .lcd_rd    (lcd_rd),
        .lcd_bl_ctr(lcd_bl_ctr),
        .ct_int    (ct_int),
        .ct_sda    (ct_sda),
        .ct_scl    (ct_scl),
        .ct_rstn   (ct_rstn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic press(input int high_clks);
        @(negedge clk) btn_clk = 1'b1;
        repeat (high_clks) @(negedge clk);
        btn_clk = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    // Select a source, queue its expected value, then decode the next full frame.
    task automatic frame_check(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] got;
        logic [31:0] want;
        int          bits;
        int          budget;
        logic        prev_wr;
        got    = 32'h0;
        bits   = 0;
        budget = FRAME_BUDGET;
        @(negedge clk) input_sel = sel;
        exp_q.push_back(exp);
        while (lcd_cs !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
        while (lcd_cs !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        prev_wr = lcd_wr;
        while (bits < 32 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (lcd_cs === 1'b0 && prev_wr === 1'b0 && lcd_wr === 1'b1) begin
                got = {got[30:0], lcd_rs};
                bits++;
            end
            prev_wr = lcd_wr;
        end
        want = exp_q.pop_front();
        if (bits < 32) check({tag, "_timeout_bits"}, 32'(bits), 32'd32);
        else           check(tag, got, want);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_cs"},      {31'h0, lcd_cs},  32'h1);
        check({tag, "_wr"},      {31'h0, lcd_wr},  32'h1);
        check({tag, "_rs"},      {31'h0, lcd_rs},  32'h0);
        check({tag, "_lcd_rst"}, {31'h0, lcd_rst}, 32'h0);
        check({tag, "_ct_rstn"}, {31'h0, ct_rstn}, 32'h0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk) #1;
        check({tag, "_lcd_rst_rel"}, {31'h0, lcd_rst}, 32'h1);
        check({tag, "_ct_rstn_rel"}, {31'h0, ct_rstn}, 32'h1);
    endtask

    initial begin
        int budget;
        resetn    = 1'b0;
        btn_clk   = 1'b0;
        input_sel = 2'd0;
        ct_int    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_pins("por");
        check("static_pins", {28'h0, lcd_rd, lcd_bl_ctr, ct_scl, ct_sda === 1'bz}, 32'hF);
        release_reset("por");

        frame_check("pc_reset", 2'd0, 32'h00000000);
        frame_check("instr_reset", 2'd1, 32'h24010001);

        repeat (3) press(20);
        frame_check("pc_3steps", 2'd0, 32'h0000000C);
        frame_check("r3_3steps", 2'd2, 32'h00000006);
        frame_check("instr_3steps", 2'd1, 32'hAC030000);

        @(negedge clk) btn_clk = 1'b1;
        repeat (DEBOUNCE_CYCLES - 1) @(negedge clk);
        btn_clk = 1'b0;
        repeat (20) @(negedge clk);
        frame_check("pc_after_glitch", 2'd0, 32'h0000000C);

        press(1000);
        frame_check("pc_after_hold", 2'd0, 32'h00000010);

        repeat (5) press(20);
        frame_check("r5_9steps", 2'd3, 32'h00000005);
        frame_check("pc_9steps", 2'd0, 32'h00000020);
        frame_check("instr_halt", 2'd1, 32'h08000008);

        repeat (2) press(20);
        frame_check("pc_halted", 2'd0, 32'h00000020);

        // Mid-frame reset after five steps.
        resetn = 1'b0;
        #3;
        release_reset("rst2");
        repeat (5) press(20);
        frame_check("pc_5steps", 2'd0, 32'h00000014);
        budget = FRAME_BUDGET;
        while (lcd_cs !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        check("midframe_cs_low", {31'h0, lcd_cs}, 32'h0);
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_pins("mid");
        btn_clk = 1'b1;
        repeat (30) @(negedge clk);
        btn_clk = 1'b0;
        repeat (5) @(negedge clk);
        release_reset("mid");
        frame_check("pc_after_mid_rst", 2'd0, 32'h00000000);
        frame_check("r3_after_mid_rst", 2'd2, 32'h00000000);
        frame_check("r5_after_mid_rst", 2'd3, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
